// File: rtl/aes_round_engine.sv
// Iterative AES encryption engine: a single round slice is reused NR times, with
// round keys fetched by index from an external key store.
//   state | meaning
//   IDLE  | ready for a plaintext block; initial AddRoundKey on accept
//   RUN   | lookup pipeline settles for LUT_LAT cycles, then the round result is captured
//   DONE  | ciphertext presented and held until out_ready
module aes_round_engine #(
  parameter int NR      = 14,
  parameter int LUT_LAT = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
    $error("aes_round_engine: NR must be 10, 12 or 14");
  end
  if (!(LUT_LAT == 1 || LUT_LAT == 2)) begin : g_bad_lat
    $error("aes_round_engine: LUT_LAT must be 1 or 2");
  end

  localparam logic [3:0] NR_W  = 4'(NR);
  localparam logic [1:0] LAT_W = 2'(LUT_LAT);

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

  fsm_t         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [3:0]   round_q, round_d;
  logic [1:0]   wait_q, wait_d;
  logic [127:0] sub_bytes, lut_out, shifted, mixed;
  logic [127:0] lut_pipe [LUT_LAT];

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse (x^254) followed by the affine map
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] x2, x3, x6, x12, p, inv;
    x2  = gmul(x, x);
    x3  = gmul(x2, x);
    x6  = gmul(x3, x3);
    x12 = gmul(x6, x6);
    p   = gmul(x12, x3);
    for (int i = 0; i < 4; i++) p = gmul(p, p);
    inv = gmul(gmul(p, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  always_comb begin
    sub_bytes = '0;
    for (int i = 0; i < 16; i++)
      sub_bytes[127-8*i -: 8] = sbox(state_q[127-8*i -: 8]);
  end

  // state_q is constant for a whole round, so the pipe settles after LUT_LAT edges
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LUT_LAT; i++) lut_pipe[i] <= '0;
    end else begin
      lut_pipe[0] <= sub_bytes;
      for (int i = 1; i < LUT_LAT; i++) lut_pipe[i] <= lut_pipe[i-1];
    end
  end

  assign lut_out = lut_pipe[LUT_LAT-1];

  always_comb begin
    shifted = '0;
    mixed   = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shifted[127-8*(4*c+r) -: 8] = lut_out[127-8*(4*((c+r)%4)+r) -: 8];
    for (int c = 0; c < 4; c++)
      mixed[127-32*c -: 32] = mix_col(shifted[127-32*c -: 32]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      round_q <= '0;
      wait_q  <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      round_q <= round_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    fsm_d     = fsm_q;
    state_d   = state_q;
    round_d   = round_q;
    wait_d    = wait_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rk_idx    = 4'd0;
    case (fsm_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = in_state ^ rk_in;
          round_d = 4'd1;
          wait_d  = 2'd0;
          fsm_d   = RUN;
        end
      end
      RUN: begin
        rk_idx = round_q;
        if (wait_q < LAT_W) begin
          wait_d = wait_q + 2'd1;
        end else begin
          wait_d = 2'd0;
          if (round_q < NR_W) begin
            state_d = mixed ^ rk_in;
            round_d = round_q + 4'd1;
          end else begin
            state_d = shifted ^ rk_in;
            fsm_d   = DONE;
          end
        end
      end
      DONE: begin
        out_valid = 1'b1;
        rk_idx    = NR_W;
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign out_state = state_q;

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: AES-256 (NR=14, LUT_LAT=1) and AES-128 (NR=10, LUT_LAT=2)
// instances checked against FIPS-197 answers and a table-driven reference model.
module tb_aes_round_engine;

  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] KEY128 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  typedef struct {
    logic         sel;
    logic [127:0] pt;
    logic [127:0] ct;
  } vec_t;

  logic         clk, rst, sel, in_valid, out_ready;
  logic [127:0] pt, cur_exp;
  logic         in_valid_a, in_ready_a, out_valid_a, in_valid_b, in_ready_b, out_valid_b;
  logic [3:0]   rk_idx_a, rk_idx_b;
  logic [127:0] rk_in_a, rk_in_b, out_state_a, out_state_b;
  logic [127:0] rk_tab [0:1][0:15];
  logic         in_ready_v, out_valid_v;
  logic [3:0]   rk_idx_v;
  logic [127:0] out_state_v;
  int           nr_v, l_v;
  int           passed = 0, total = 0;

  assign in_valid_a  = in_valid & ~sel;
  assign in_valid_b  = in_valid & sel;
  assign rk_in_a     = rk_tab[0][rk_idx_a];
  assign rk_in_b     = rk_tab[1][rk_idx_b];
  assign in_ready_v  = sel ? in_ready_b : in_ready_a;
  assign out_valid_v = sel ? out_valid_b : out_valid_a;
  assign rk_idx_v    = sel ? rk_idx_b : rk_idx_a;
  assign out_state_v = sel ? out_state_b : out_state_a;
  assign nr_v        = sel ? 10 : 14;
  assign l_v         = sel ? 2 : 1;

  aes_round_engine #(.NR(14), .LUT_LAT(1)) u_aes256 (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_state(pt),
    .rk_idx(rk_idx_a), .rk_in(rk_in_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_state(out_state_a));

  aes_round_engine #(.NR(10), .LUT_LAT(2)) u_aes128 (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_state(pt),
    .rk_idx(rk_idx_b), .rk_in(rk_in_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_state(out_state_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  function automatic logic [7:0] sb(input logic [7:0] x);
    logic [2047:0] t;
    t = SBOX;
    return t[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb(w[31:24]), sb(w[23:16]), sb(w[15:8]), sb(w[7:0])};
  endfunction

  task automatic expand(input int s, input logic [255:0] key, input int nk, input int nr);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 60; i++) w[i] = '0;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    rc = 8'h01;
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_tab[s][r] = '0;
    for (int r = 0; r <= nr; r++) rk_tab[s][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  function automatic logic [127:0] ref_enc(input logic s, input logic [127:0] p);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] st, nx;
    int           nr;
    nr = s ? 10 : 14;
    st = p ^ rk_tab[s][0];
    for (int r = 1; r <= nr; r++) begin
      for (int i = 0; i < 16; i++) b[i] = st[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
        for (int w = 0; w < 4; w++) t[4*c+w] = sb(b[4*((c+w)%4)+w]);
      nx = '0;
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        if (r < nr)
          nx[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3, a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3, xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        else
          nx[127-32*c -: 32] = {a0, a1, a2, a3};
      end
      st = nx ^ rk_tab[s][r];
    end
    return st;
  endfunction

  // Monitor / scoreboard: samples on the falling edge, predicts the next rising edge.
  int           cyc = 0, acc_cyc = 0, hs_cyc = 0;
  logic         busy = 1'b0, ov_prev = 1'b0, rk_ok = 1'b1;
  logic [127:0] held = '0;
  logic [127:0] exp_q [$];

  always @(negedge clk) begin : mon
    int           k;
    logic [3:0]   erk;
    logic [127:0] e;
    if (rst) begin
      exp_q.delete();
      busy    = 1'b0;
      ov_prev = 1'b0;
    end else begin
      if (busy && !out_valid_v) begin
        k   = cyc - acc_cyc;
        erk = 4'((k - 1) / (l_v + 1) + 1);
        if (rk_idx_v !== erk) rk_ok = 1'b0;
      end
      if (out_valid_v && !ov_prev) begin
        check("out_valid_expected", 128'(busy), 128'(1));
        check("latency", 128'(cyc - acc_cyc - 1), 128'(nr_v * (l_v + 1)));
        check("rk_sequence", 128'(rk_ok), 128'(1));
        held = out_state_v;
      end else if (out_valid_v) begin
        check("held_state", out_state_v, held);
      end
      if (out_valid_v) begin
        check("done_in_ready", 128'(in_ready_v), 128'(0));
        check("done_rk_idx", 128'(rk_idx_v), 128'(nr_v));
      end
      if (out_valid_v && out_ready) begin
        hs_cyc = cyc;
        check("scoreboard_depth", 128'(exp_q.size()), 128'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("ciphertext", out_state_v, e);
        end
        busy = 1'b0;
      end
      if (in_valid && in_ready_v) begin
        acc_cyc = cyc;
        busy    = 1'b1;
        rk_ok   = (rk_idx_v === 4'd0);
        exp_q.push_back(cur_exp);
      end
      ov_prev = out_valid_v;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic submit(input logic [127:0] p, input logic [127:0] e, output int t_acc);
    logic ok;
    tick();
    pt       = p;
    cur_exp  = e;
    in_valid = 1'b1;
    t_acc    = -1;
    for (int n = 0; n < 200 && t_acc < 0; n++) begin
      @(negedge clk);
      ok = in_ready_v && !rst;
      tick();
      if (ok) t_acc = acc_cyc;
    end
    if (t_acc < 0) check("accept_timeout", 128'(0), 128'(1));
  endtask

  task automatic wait_done();
    for (int n = 0; n < 200 && busy; n++) tick();
    check("drain", 128'(busy), 128'(0));
  endtask

  vec_t         vecs [0:5];
  logic [127:0] spt [0:3];
  logic [127:0] bpt;
  int           t, ta [0:3], sp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sel = 1'b0; pt = '0; cur_exp = '0;
    expand(0, KEY256, 8, 14);
    expand(1, {KEY128, 128'h0}, 4, 10);
    vecs[0].sel = 1'b0; vecs[0].pt = PT;          vecs[0].ct = CT256;
    vecs[1].sel = 1'b1; vecs[1].pt = PT;          vecs[1].ct = CT128;
    vecs[2].sel = 1'b0; vecs[2].pt = '0;          vecs[2].ct = ref_enc(1'b0, '0);
    vecs[3].sel = 1'b1; vecs[3].pt = '1;          vecs[3].ct = ref_enc(1'b1, '1);
    vecs[4].sel = 1'b0; vecs[4].pt = {$urandom, $urandom, $urandom, $urandom};
    vecs[4].ct  = ref_enc(1'b0, vecs[4].pt);
    vecs[5].sel = 1'b1; vecs[5].pt = {$urandom, $urandom, $urandom, $urandom};
    vecs[5].ct  = ref_enc(1'b1, vecs[5].pt);
    spt[0] = PT;
    for (int i = 1; i < 4; i++) spt[i] = {$urandom, $urandom, $urandom, $urandom};
    bpt = {$urandom, $urandom, $urandom, $urandom};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready_a", 128'(in_ready_a), 128'(1));
    check("rst_out_valid_a", 128'(out_valid_a), 128'(0));
    check("rst_out_state_a", out_state_a, '0);
    check("rst_rk_idx_a", 128'(rk_idx_a), 128'(0));
    check("rst_in_ready_b", 128'(in_ready_b), 128'(1));
    check("rst_out_valid_b", 128'(out_valid_b), 128'(0));
    check("rst_out_state_b", out_state_b, '0);
    check("rst_rk_idx_b", 128'(rk_idx_b), 128'(0));
    tick();
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      sel = vecs[i].sel;
      submit(vecs[i].pt, vecs[i].ct, t);
      in_valid = 1'b0;
      wait_done();
    end

    // back-pressure with a second block waiting at the input
    sel = 1'b0;
    out_ready = 1'b0;
    submit(PT, CT256, t);
    in_valid = 1'b0;
    for (int n = 0; n < 100 && !out_valid_v; n++) tick();
    check("bp_out_valid", 128'(out_valid_v), 128'(1));
    pt = bpt; cur_exp = ref_enc(1'b0, bpt); in_valid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", 128'(in_ready_v), 128'(0));
      check("bp_out_state", out_state_v, CT256);
    end
    tick();
    out_ready = 1'b1;
    submit(bpt, ref_enc(1'b0, bpt), t);
    check("bp_accept_gap", 128'(t - hs_cyc), 128'(1));
    in_valid = 1'b0;
    wait_done();

    // reset during round 7
    submit(PT, CT256, t);
    in_valid = 1'b0;
    repeat (12) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 128'(in_ready_v), 128'(1));
    check("midrst_out_valid", 128'(out_valid_v), 128'(0));
    check("midrst_out_state", out_state_v, '0);
    check("midrst_rk_idx", 128'(rk_idx_v), 128'(0));
    tick();
    // in_valid coinciding with reset must not be accepted
    rst = 1'b1; pt = PT; in_valid = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0;
    sp = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid_v || !in_ready_v) sp++;
    end
    check("no_spurious_activity", 128'(sp), 128'(0));
    submit(PT, CT256, t);
    in_valid = 1'b0;
    wait_done();

    // streaming, out_ready tied high
    for (int i = 0; i < 4; i++) begin
      submit(spt[i], ref_enc(1'b0, spt[i]), ta[i]);
      if (i > 0) check("stream_gap", 128'(ta[i] - ta[i-1]), 128'(30));
    end
    in_valid = 1'b0;
    wait_done();

    check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
